// File: rtl/bcd_to_bin_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin_if
// Purpose  : Request/response bundle for the BCD-to-binary converter.
//            master : issues start_i with tens_i/ones_i and observes results
//            slave  : the converter; returns bin_o, valid_o, busy_o, err_o
// Signals  : start_i  conversion request
//            tens_i   BCD tens digit (0-9)
//            ones_i   BCD ones digit (0-9)
//            bin_o    registered binary result
//            valid_o  one-cycle pulse, new bin_o
//            busy_o   conversion in progress
//            err_o    one-cycle pulse, request rejected (non-BCD digit)
// Revision : 1.0 - initial release
// ============================================================================
interface bcd_to_bin_if #(
    parameter int N_SHIFT = 7
);
    logic               start_i;
    logic [3:0]         tens_i;
    logic [3:0]         ones_i;
    logic [N_SHIFT-1:0] bin_o;
    logic               valid_o;
    logic               busy_o;
    logic               err_o;

    modport master (
        output start_i, tens_i, ones_i,
        input  bin_o, valid_o, busy_o, err_o
    );

    modport slave (
        input  start_i, tens_i, ones_i,
        output bin_o, valid_o, busy_o, err_o
    );
endinterface
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Two-digit BCD to binary converter using a sequential reverse
//            double-dabble: one shift/correct step per clock, N_SHIFT steps
//            per conversion, one result every N_SHIFT+1 cycles.
// Ports    : clk_i  system clock (rising edge)
//            rst_i  asynchronous active-low reset
//            bus    bcd_to_bin_if.slave (start/tens/ones in,
//                   bin/valid/busy/err out)
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin #(
    parameter int N_SHIFT = 7
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    bcd_to_bin_if.slave bus
);
    localparam int CNT_W = $clog2(N_SHIFT + 1);

    localparam logic [0:0] c_idle  = 1'b0;
    localparam logic [0:0] c_shift = 1'b1;

    logic [0:0]         r_state;
    logic [7:0]         r_bcd;
    logic [N_SHIFT-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [N_SHIFT-1:0] r_bin;
    logic               r_valid;
    logic               r_err;

    logic               w_legal;
    logic [7:0]         w_bcd_sh;
    logic [7:0]         w_bcd_next;
    logic [N_SHIFT-1:0] w_acc_next;

    assign w_legal = (bus.tens_i <= 4'd9) && (bus.ones_i <= 4'd9);

    // Right shift of {bcd, acc}: the bcd LSB drops into the accumulator MSB.
    assign w_bcd_sh   = {1'b0, r_bcd[7:1]};
    assign w_acc_next = {r_bcd[0], r_acc[N_SHIFT-1:1]};

    // A shifted nibble >= 8 means a "ten" moved down from the digit above
    // as binary weight 8; subtracting 3 restores its decimal weight of 5.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_nibble
            assign w_bcd_next[g*4 +: 4] = (w_bcd_sh[g*4 +: 4] >= 4'd8) ?
                                          (w_bcd_sh[g*4 +: 4] - 4'd3) :
                                           w_bcd_sh[g*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_idle;
            r_bcd   <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                c_idle: begin
                    if (bus.start_i) begin
                        if (w_legal) begin
                            r_bcd   <= {bus.tens_i, bus.ones_i};
                            r_acc   <= '0;
                            r_cnt   <= CNT_W'(N_SHIFT);
                            r_state <= c_shift;
                        end else begin
                            r_err   <= 1'b1;
                        end
                    end
                end
                c_shift: begin
                    r_bcd <= w_bcd_next;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    // Last step: publish the accumulator as it leaves this step.
                    if (r_cnt == CNT_W'(1)) begin
                        r_bin   <= w_acc_next;
                        r_valid <= 1'b1;
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    assign bus.bin_o   = r_bin;
    assign bus.valid_o = r_valid;
    assign bus.err_o   = r_err;
    assign bus.busy_o  = (r_state == c_shift);

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Purpose  : Self-checking bench for bcd_to_bin. A driver issues directed and
//            random requests and pushes the expected events (result or
//            rejection, with the edge on which each must appear) into a
//            scoreboard queue; a monitor pops and compares on every valid_o
//            or err_o, and tracks busy_o and bin_o each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;
    typedef struct {
        bit is_err;
        int val;
        int cyc;
    } ev_t;

    logic clk_i = 1'b0;
    logic rst_i;

    bcd_to_bin_if #(.N_SHIFT(7)) bif ();

    bcd_to_bin #(.N_SHIFT(7)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bif)
    );

    always #5 clk_i = ~clk_i;

    int  cyc       = 0;     // number of rising edges so far
    int  free_edge = 0;     // edge of the last expected valid_o
    int  exp_bin   = 0;
    bit  in_reset  = 1'b1;
    int  n_checks  = 0;
    int  n_fail    = 0;
    ev_t sb[$];

    always @(posedge clk_i) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive inputs for the next rising edge and predict the response.
    task automatic drive_now(input bit s, input int t, input int o);
        int e;
        bif.start_i = s;
        bif.tens_i  = 4'(t);
        bif.ones_i  = 4'(o);
        e = cyc + 1;
        // The converter is idle again only after the edge that shows valid_o.
        if (s && e > free_edge) begin
            if (t <= 9 && o <= 9) begin
                sb.push_back('{1'b0, 10 * t + o, e + 7});
                free_edge = e + 7;
            end else begin
                sb.push_back('{1'b1, 0, e});
            end
        end
    endtask

    task automatic drive(input bit s, input int t, input int o);
        @(negedge clk_i);
        drive_now(s, t, o);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_bin",   int'(bif.bin_o),   0);
        check("rst_valid", int'(bif.valid_o), 0);
        check("rst_busy",  int'(bif.busy_o),  0);
        check("rst_err",   int'(bif.err_o),   0);
    endtask

    // Monitor
    initial begin
        ev_t ev;
        forever begin
            @(posedge clk_i);
            #1;
            if (!in_reset) begin
                check("valid_err_excl", int'(bif.valid_o && bif.err_o), 0);
                if (bif.valid_o || bif.err_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_event", 1, 0);
                    end else begin
                        ev = sb.pop_front();
                        check("event_kind",  int'(bif.err_o), int'(ev.is_err));
                        check("event_cycle", cyc, ev.cyc);
                        if (!ev.is_err) exp_bin = ev.val;
                    end
                end
                check("busy", int'(bif.busy_o), int'(cyc < free_edge));
                check("bin",  int'(bif.bin_o),  exp_bin);
            end
        end
    end

    // Stimulus
    initial begin
        rst_i       = 1'b0;
        bif.start_i = 1'b0;
        bif.tens_i  = 4'd0;
        bif.ones_i  = 4'd0;
        repeat (2) @(negedge clk_i);
        #1 check_reset_outputs();

        // Release and request on the very first edge: 0,0.
        @(negedge clk_i);
        rst_i    = 1'b1;
        in_reset = 1'b0;
        drive_now(1'b1, 0, 0);
        idle(9);

        // 15.
        drive(1'b1, 1, 5);
        idle(9);

        // 99 then 42 accepted on the valid_o cycle.
        drive(1'b1, 9, 9);
        idle(7);
        drive(1'b1, 4, 2);
        idle(9);

        // Rejected request.
        drive(1'b1, 10, 3);
        idle(3);

        // 73 with start held and operands changed while busy.
        drive(1'b1, 7, 3);
        repeat (7) drive(1'b1, 9, 9);
        idle(9);

        // Reset mid-conversion.
        drive(1'b1, 5, 5);
        idle(3);
        @(negedge clk_i);
        #1 rst_i = 1'b0;
        in_reset = 1'b1;
        #1 check_reset_outputs();
        sb.delete();
        free_edge = 0;
        exp_bin   = 0;
        repeat (3) @(negedge clk_i);
        rst_i    = 1'b1;
        in_reset = 1'b0;
        drive_now(1'b1, 6, 8);
        idle(9);

        // Random traffic, including illegal digits and starts while busy.
        for (int i = 0; i < 500; i++) begin
            drive(bit'($urandom_range(0, 1)),
                  int'($urandom_range(0, 11)),
                  int'($urandom_range(0, 11)));
        end
        idle(1);

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk_i);
        check("drain_pending", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 SHALL have parameter N_SHIFT, default 7, meaning the number of shift iterations per conversion (equal to the bin_o width).
REQ-002 SHALL have port clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  conversion request; sampled on a rising edge only while idle.
REQ-005 SHALL have port tens_i  input  4  BCD tens digit; valid range 0-9.
REQ-006 SHALL have port ones_i  input  4  BCD ones digit; valid range 0-9.
REQ-007 SHALL have port bin_o  output  7  binary result, registered; holds the last successful result.
REQ-008 SHALL have port valid_o  output  1  one-cycle pulse marking a new bin_o.
REQ-009 SHALL have port busy_o  output  1  high while a conversion is in progress.
REQ-010 SHALL have port err_o  output  1  one-cycle pulse marking a rejected request with a non-BCD digit.

Function
REQ-011 SHALL implement two states: IDLE and SHIFT.
REQ-012 IDLE, start_i=1, tens_i<=9 and ones_i<=9: SHALL capture {tens_i,ones_i} into an 8-bit BCD register and clear a 7-bit binary accumulator.
- Same edge: SHALL load iteration counter with N_SHIFT, go to SHIFT, set busy_o=1.
REQ-013 IDLE, start_i=1, tens_i>9 or ones_i>9: SHALL assert err_o for exactly one cycle.
- SHALL stay in IDLE; bin_o and busy_o unchanged; valid_o=0.
REQ-014 SHIFT: each rising edge SHALL perform one reverse-double-dabble step:
- Shift the 15-bit concatenation {bcd,acc} right by one.
- Then subtract 3 from every BCD nibble whose shifted value is >=8.
- Decrement the counter.
REQ-015 On the SHIFT edge where the counter goes from 1 to 0, SHALL:
- Load bin_o with the final accumulator.
- Set valid_o=1 and busy_o=0; return to IDLE.
REQ-016 Latency: request sampled at edge k SHALL give busy_o=1 after edges k..k+6 and valid_o=1 only after edge k+7.
- New bin_o is visible after edge k+7.
REQ-017 The result SHALL equal 10*tens_i+ones_i for every legal pair (range 0-99, fits 7 bits, no overflow possible).
REQ-018 valid_o and err_o SHALL each be high for exactly one cycle per event and never high together.
REQ-019 start_i while busy_o=1 SHALL be ignored: no restart, no err_o, captured operands unaffected.
REQ-020 Back-to-back requests:
- start_i high in the cycle valid_o=1 (state IDLE) SHALL be accepted at that edge.
- Throughput is one result per 8 cycles.
REQ-021 Changes on tens_i/ones_i after the capture edge SHALL NOT affect the in-flight result.
REQ-022 bin_o SHALL change only on the REQ-015 edge or on reset.

Reset
REQ-023 rst_i=0 SHALL immediately force: state IDLE, bin_o=0, valid_o=0, busy_o=0, err_o=0, counter=0, BCD and accumulator registers=0.
REQ-024 Reset asserted mid-conversion SHALL abort it; no valid_o SHALL follow the release.
REQ-025 After rst_i returns to 1, the first rising edge SHALL accept a start_i normally.

Verification
REQ-026 Reset, then start with tens=0, ones=0 -> valid_o pulse 7 edges after capture, bin_o=0.
REQ-027 Start tens=1, ones=5 -> busy_o high for 7 cycles, then bin_o=15 (0001111) with a single valid_o pulse.
REQ-028 Start tens=9, ones=9, then tens=4, ones=2 back-to-back on the valid_o cycle -> bin_o=99 then bin_o=42, 8 cycles apart.
REQ-029 Start tens=10, ones=3 -> err_o one-cycle pulse, busy_o stays 0, bin_o keeps its previous value.
REQ-030 Start tens=7, ones=3, hold start_i high with tens=9, ones=9 during busy -> bin_o=73 only, one valid_o, no err_o.
REQ-031 Start tens=5, ones=5, pull rst_i low 3 cycles later -> outputs 0 immediately, no valid_o after release, next start converts correctly.
